// File: rtl/fifo_rd_packer_if.sv
// FIFO read port plus packed valid/ready output stream of fifo_rd_packer.
// master is the packer side, slave is the FIFO/downstream side.
interface fifo_rd_packer_if #(
  parameter int WIDTH_D = 16,
  parameter int PACK    = 2
);
  logic                       r_req;
  logic                       r_empty;
  logic [WIDTH_D-1:0]         r_data;
  logic                       m_valid;
  logic                       m_ready;
  logic [WIDTH_D*PACK-1:0]    m_data;
  logic [PACK-1:0]            m_keep;

  modport master (
    output r_req,
    input  r_empty,
    input  r_data,
    output m_valid,
    input  m_ready,
    output m_data,
    output m_keep
  );

  modport slave (
    input  r_req,
    output r_empty,
    output r_data,
    input  m_valid,
    output m_ready,
    input  m_data,
    input  m_keep
  );
endinterface

// File: rtl/fifo_rd_packer.sv
// Read-side FIFO consumer: fetches words, absorbs read latency in a small
// buffer and packs PACK words per output beat, with flush of partial beats.
module fifo_rd_packer #(
  parameter int WIDTH_D   = 16,
  parameter int PACK      = 2,
  parameter int BUF_DEPTH = 4
) (
  input  logic               r_clk,
  input  logic               r_rst,
  input  logic               en,
  input  logic               flush,
  output logic               idle,
  fifo_rd_packer_if.master   bus
);
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int KW = $clog2(PACK);
  localparam logic [CW:0]   DEPTH_EXT = (CW + 1)'(BUF_DEPTH);
  localparam logic [CW-1:0] DEPTH_CNT = CW'(BUF_DEPTH);
  localparam logic [PW-1:0] PTR_LAST  = PW'(BUF_DEPTH - 1);
  localparam logic [KW-1:0] CNT_LAST  = KW'(PACK - 1);

  typedef enum logic [1:0] {RUN, DRAIN, EMIT} state_t;

  state_t                  state;
  logic [WIDTH_D-1:0]      buf_mem [BUF_DEPTH];
  logic [PW-1:0]           wr_ptr;
  logic [PW-1:0]           rd_ptr;
  logic [CW-1:0]           buf_cnt;
  logic                    inflight;
  logic [WIDTH_D-1:0]      asm_word [PACK];
  logic [KW-1:0]           cnt;

  logic                    room;
  logic                    slot_free;
  logic                    pop;
  logic [WIDTH_D-1:0]      pop_word;
  logic [WIDTH_D*PACK-1:0] full_beat;
  logic [WIDTH_D*PACK-1:0] part_beat;
  logic [PACK-1:0]         part_keep;

  // Room counts the word still in flight so the buffer can never be overrun.
  assign room      = ({1'b0, buf_cnt} + (CW + 1)'(inflight)) < DEPTH_EXT;
  assign bus.r_req = !r_rst && en && !bus.r_empty && room && (state == RUN);
  assign slot_free = !bus.m_valid || bus.m_ready;
  assign pop       = (buf_cnt != '0) && ((cnt != CNT_LAST) || slot_free);
  assign pop_word  = buf_mem[rd_ptr];
  assign idle      = (buf_cnt == '0) && !inflight && (cnt == '0) &&
                     !bus.m_valid && (state == RUN);

  always_comb begin
    full_beat = '0;
    part_beat = '0;
    part_keep = '0;
    for (int i = 0; i < PACK; i++) begin
      if (i == PACK - 1) begin
        full_beat[i*WIDTH_D +: WIDTH_D] = pop_word;
      end else begin
        full_beat[i*WIDTH_D +: WIDTH_D] = asm_word[i];
      end
      if (i < int'(cnt)) begin
        part_beat[i*WIDTH_D +: WIDTH_D] = asm_word[i];
        part_keep[i]                    = 1'b1;
      end
    end
  end

  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      state       <= RUN;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      buf_cnt     <= '0;
      inflight    <= 1'b0;
      cnt         <= '0;
      bus.m_valid <= 1'b0;
      bus.m_data  <= '0;
      bus.m_keep  <= '0;
    end else begin
      assert (!(inflight && !pop && (buf_cnt == DEPTH_CNT)));
      inflight <= bus.r_req;
      if (inflight) begin
        buf_mem[wr_ptr] <= bus.r_data;
        wr_ptr          <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      end
      buf_cnt <= buf_cnt + CW'(inflight) - CW'(pop);

      if (bus.m_valid && bus.m_ready) begin
        bus.m_valid <= 1'b0;
      end

      // The final word of a beat bypasses the assembly register straight out.
      if (pop) begin
        if (cnt == CNT_LAST) begin
          bus.m_data  <= full_beat;
          bus.m_keep  <= '1;
          bus.m_valid <= 1'b1;
          cnt         <= '0;
        end else begin
          asm_word[cnt] <= pop_word;
          cnt           <= cnt + 1'b1;
        end
      end

      case (state)
        RUN: begin
          if (flush) state <= DRAIN;
        end
        DRAIN: begin
          if (!inflight && (buf_cnt == '0)) begin
            state <= (cnt != '0) ? EMIT : RUN;
          end
        end
        EMIT: begin
          if (slot_free) begin
            bus.m_data  <= part_beat;
            bus.m_keep  <= part_keep;
            bus.m_valid <= 1'b1;
            cnt         <= '0;
            state       <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end
endmodule

// File: doc/fifo_rd_packer.md
Name: fifo_rd_packer

Overview:
- Read-side consumer of the asynchronous FIFO; runs entirely in the read clock domain.
- Drives the FIFO read request and absorbs its one-cycle read latency in a small word buffer.
- Packs PACK consecutive WIDTH_D words into one wide beat on a valid/ready output stream.
- A flush input forces out a partially filled beat, zero-padded, with a per-word keep mask.

Parameters:
WIDTH_D, 16, FIFO word width.
PACK, 2, words per output beat (>=2).
BUF_DEPTH, 4, word buffer entries (>=3; 3 is the minimum for 1 word/cycle sustained).

Ports:
r_clk  in  1  read-domain clock.
r_rst  in  1  synchronous, active-high reset.
en  in  1  fetch enable; 0 blocks new FIFO reads, packing continues.
flush  in  1  single-cycle pulse; emit the pending partial beat.
r_req  out  1  FIFO read request.
r_empty  in  1  FIFO empty flag.
r_data  in  WIDTH_D  FIFO read data, valid the cycle after an accepted read.
m_valid  out  1  output beat valid.
m_ready  in  1  downstream ready.
m_data  out  WIDTH_D*PACK  packed beat; word 0 in bits [WIDTH_D-1:0].
m_keep  out  PACK  bit i = word i of m_data is real data.
idle  out  1  buffer empty, nothing in flight, no partial words, !m_valid, state RUN.

Behaviour:
- One clock; reset is synchronous and active-high on r_clk/r_rst.
- Reset (sampled high at a rising edge):
  - r_req=0, m_valid=0, m_data=0, m_keep=0, idle=1 from the next cycle.
  - Buffer count, in-flight flag and partial count cleared; FSM returns to RUN.
  - A read accepted in the reset cycle is discarded.
- Fetch:
  - r_req = en & !r_empty & (buf_cnt + inflight < BUF_DEPTH) & (state==RUN).
  - Combinational; an accepted read is exactly r_req.
  - inflight is a register equal to the previous cycle's r_req.
  - When inflight=1, r_data is written into the buffer at that edge.
  - The buffer never overflows; an overflow is an assertion failure.
- Packing:
  - An assembly register holds cnt (0..PACK-1) words.
  - A word is popped when the buffer is non-empty and either cnt<PACK-1, or the output slot is free (!m_valid | m_ready).
  - The word is placed in slot cnt.
  - On the PACK-th word, the full beat (assembly plus the popped word) loads the output register in the same edge: m_keep all ones, cnt←0.
  - At most one pop per cycle.
- Output:
  - m_data and m_keep hold stable while m_valid & !m_ready.
  - Transfer occurs on m_valid & m_ready.
  - The output register reloads in the same cycle it transfers (no bubble).
- Latency:
  - Read accepted at cycle t, data in the buffer after edge t+1, popped at t+2 earliest.
  - m_valid for a beat rises at t+3 relative to the read of its last word.
  - Sustained throughput is 1 word/cycle with m_ready=1 and the FIFO non-empty.
- FSM:
  - RUN: normal operation. flush=1 → DRAIN.
  - DRAIN: r_req=0; keep packing in-flight and buffered words. When inflight=0 and buf_cnt=0: cnt>0 → EMIT, else → RUN.
  - EMIT: when the output slot is free, load the output register with assembly words in slots 0..cnt-1, zeros elsewhere, m_keep = (1<<cnt)-1; cnt←0 → RUN.
  - flush in DRAIN/EMIT is ignored. A flush arriving in the same cycle as a completing full beat takes effect after that beat.
- en=0 does not stop draining or output. en toggles only gate r_req.
- Wrap of buffer pointers is modulo BUF_DEPTH. Counters are sized for 0..BUF_DEPTH inclusive.

Test Plan:
- Reset: r_rst=1 for 2 cycles with the FIFO non-empty → r_req=0, m_valid=0, m_data=0, m_keep=0, idle=1.
- Streaming: FIFO holds 0x0001..0x0008, m_ready=1, en=1 → r_req high 8 consecutive cycles. Beats 0x00020001, 0x00040003, 0x00060005, 0x00080007, each m_keep=2'b11. First m_valid 3 cycles after the second read; one beat every 2 cycles after that.
- Backpressure: 16 words queued, m_ready=0 for 10 cycles → r_req drops once buf_cnt+inflight=4. m_data stays 0x00020001 throughout. After release, all 8 beats arrive in order with none lost or duplicated.
- Flush odd count: words 0x00A1, 0x00A2, 0x00A3, then flush → beats 0x00A200A1 with keep 11, then 0x000000A3 with keep 01. FSM back in RUN; idle=1 afterwards.
- Empty/flush-no-data: r_empty=1 → r_req=0, m_valid stays 0. flush with cnt=0 → DRAIN→RUN with no beat emitted.
- Reset mid-stream: r_rst during backpressure with 3 words buffered and 1 partial word → next cycle all outputs at reset values. A subsequent 2-word stream produces a clean beat with keep 11.
